// File: rtl/riscv_seq_pkg.sv
// Shared types and constants for the RV32I test sequencer.
package riscv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    CHECK_REQ,
    CMP,
    DONE
  } seq_state_t;

  localparam logic CFG_PROG  = 1'b0;
  localparam logic CFG_CHECK = 1'b1;

  localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/riscv_seq_check_table.sv
// Expected-register table: one write port, one combinational read port.
module riscv_seq_check_table
  import riscv_seq_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int NUM_CHECKS = 8,
  localparam int CK_W       = $clog2(NUM_CHECKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [CK_W-1:0]       wr_idx,
  input  logic [REG_ADDR_W-1:0] wr_reg,
  input  logic [XLEN-1:0]       wr_data,
  input  logic [CK_W-1:0]       rd_idx,
  output logic                  rd_valid,
  output logic [REG_ADDR_W-1:0] rd_reg,
  output logic [XLEN-1:0]       rd_data
);

  logic [NUM_CHECKS-1:0] valid_q;
  logic [REG_ADDR_W-1:0] reg_q [NUM_CHECKS];
  logic [XLEN-1:0]       exp_q [NUM_CHECKS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        reg_q[i] <= '0;
        exp_q[i] <= '0;
      end
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      reg_q[wr_idx]   <= wr_reg;
      exp_q[wr_idx]   <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_reg   = reg_q[rd_idx];
  assign rd_data  = exp_q[rd_idx];

endmodule

// File: rtl/riscv_test_sequencer.sv
// Run controller for the RV32I core: loads imem, runs to HALT or timeout, checks registers.
// state     | meaning
// IDLE      | accepting config, core held in reset
// RUN       | core released, cycle counter running
// DRAIN     | core halted, waiting for write-backs to retire
// CHECK_REQ | scanning slots, issuing dbg_raddr for the next valid one
// CMP       | comparing dbg_rdata against the slot's expected value
// DONE      | results latched, core held in reset, accepting config
module riscv_test_sequencer
  import riscv_seq_pkg::*;
#(
  parameter  int XLEN           = 32,
  parameter  int IMEM_DEPTH     = 64,
  parameter  int NUM_CHECKS     = 8,
  parameter  int TIMEOUT_CYCLES = 280,
  parameter  int DRAIN_CYCLES   = 4,
  localparam int ADDR_W         = $clog2(IMEM_DEPTH),
  localparam int CK_W           = $clog2(NUM_CHECKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  cfg_sel,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [REG_ADDR_W-1:0] cfg_reg,
  input  logic [XLEN-1:0]       cfg_data,
  input  logic                  start,
  output logic                  imem_we,
  output logic [ADDR_W-1:0]     imem_addr,
  output logic [XLEN-1:0]       imem_wdata,
  output logic                  core_rst_n,
  input  logic                  core_halted,
  output logic [REG_ADDR_W-1:0] dbg_raddr,
  input  logic [XLEN-1:0]       dbg_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CK_W:0]         fail_cnt,
  output logic [CK_W-1:0]       first_fail
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DR_W  = $clog2(DRAIN_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DR_W-1:0]  DR_LOAD  = DR_W'(DRAIN_CYCLES - 1);
  localparam logic [CK_W-1:0]  IDX_LAST = CK_W'(NUM_CHECKS - 1);

  seq_state_t            state;
  logic [CNT_W-1:0]      run_cnt;
  logic [DR_W-1:0]       drain_cnt;
  logic [CK_W-1:0]       idx;
  logic                  cfg_acc;
  logic                  prog_wr;
  logic                  tbl_we;
  logic                  slot_valid;
  logic [REG_ADDR_W-1:0] slot_reg;
  logic [XLEN-1:0]       slot_exp;
  logic                  mismatch;
  logic [CK_W:0]         fail_cnt_nxt;

  assign cfg_ready    = (state == IDLE) || (state == DONE);
  assign cfg_acc      = cfg_valid & cfg_ready;
  assign prog_wr      = cfg_acc & (cfg_sel == CFG_PROG);
  assign tbl_we       = cfg_acc & (cfg_sel == CFG_CHECK);
  assign mismatch     = (dbg_rdata != slot_exp);
  assign fail_cnt_nxt = fail_cnt + {{CK_W{1'b0}}, mismatch};

  riscv_seq_check_table #(
    .XLEN       (XLEN),
    .NUM_CHECKS (NUM_CHECKS)
  ) u_check_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (tbl_we),
    .wr_idx   (cfg_addr[CK_W-1:0]),
    .wr_reg   (cfg_reg),
    .wr_data  (cfg_data),
    .rd_idx   (idx),
    .rd_valid (slot_valid),
    .rd_reg   (slot_reg),
    .rd_data  (slot_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      run_cnt    <= '0;
      drain_cnt  <= '0;
      idx        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      dbg_raddr  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      fail_cnt   <= '0;
      first_fail <= '0;
    end else begin
      imem_we <= prog_wr;
      if (prog_wr) begin
        imem_addr  <= cfg_addr;
        imem_wdata <= cfg_data;
      end

      case (state)
        IDLE, DONE: begin
          // A config write in the same cycle takes priority over start.
          if (start && !cfg_valid) begin
            state      <= RUN;
            run_cnt    <= '0;
            idx        <= '0;
            timeout    <= 1'b0;
            fail_cnt   <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
            core_rst_n <= 1'b1;
          end
        end

        RUN: begin
          run_cnt <= run_cnt + 1'b1;
          if (core_halted) begin
            state     <= DRAIN;
            drain_cnt <= DR_LOAD;
          end else if (run_cnt == CNT_LAST) begin
            timeout <= 1'b1;
            idx     <= '0;
            state   <= CHECK_REQ;
          end
        end

        DRAIN: begin
          if (drain_cnt == '0) begin
            idx   <= '0;
            state <= CHECK_REQ;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end

        CHECK_REQ: begin
          if (slot_valid) begin
            dbg_raddr <= slot_reg;
            state     <= CMP;
          end else if (idx == IDX_LAST) begin
            state      <= DONE;
            done       <= 1'b1;
            busy       <= 1'b0;
            core_rst_n <= 1'b0;
            pass       <= (fail_cnt == '0) && !timeout;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        CMP: begin
          fail_cnt <= fail_cnt_nxt;
          if (mismatch && (fail_cnt == '0)) begin
            first_fail <= idx;
          end
          if (idx == IDX_LAST) begin
            state      <= DONE;
            done       <= 1'b1;
            busy       <= 1'b0;
            core_rst_n <= 1'b0;
            pass       <= (fail_cnt_nxt == '0) && !timeout;
          end else begin
            idx   <= idx + 1'b1;
            state <= CHECK_REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_test_sequencer.sv
// Scoreboard bench for riscv_test_sequencer with a tiny behavioural RV32I core.
module tb_riscv_test_sequencer;

  localparam int XLEN       = 32;
  localparam int IMEM_DEPTH = 64;
  localparam int NUM_CHECKS = 8;
  localparam int TIMEOUT    = 40;
  localparam int DRAIN      = 4;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_sel;
  logic [5:0]  cfg_addr;
  logic [4:0]  cfg_reg;
  logic [31:0] cfg_data;
  logic        start;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        core_halted;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [3:0]  fail_cnt;
  logic [2:0]  first_fail;

  riscv_test_sequencer #(
    .XLEN           (XLEN),
    .IMEM_DEPTH     (IMEM_DEPTH),
    .NUM_CHECKS     (NUM_CHECKS),
    .TIMEOUT_CYCLES (TIMEOUT),
    .DRAIN_CYCLES   (DRAIN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_sel     (cfg_sel),
    .cfg_addr    (cfg_addr),
    .cfg_reg     (cfg_reg),
    .cfg_data    (cfg_data),
    .start       (start),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .core_rst_n  (core_rst_n),
    .core_halted (core_halted),
    .dbg_raddr   (dbg_raddr),
    .dbg_rdata   (dbg_rdata),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .fail_cnt    (fail_cnt),
    .first_fail  (first_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural core: one instruction per cycle, EBREAK halts
  logic [31:0] imem_m [IMEM_DEPTH];
  logic [31:0] regs   [32];
  logic [31:0] pc_m;
  logic        halted_m;
  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_j;
  logic        wb_en, halt_now;
  logic [31:0] wb_val, pc_nxt;

  assign core_halted = halted_m;
  assign dbg_rdata   = regs[dbg_raddr];
  assign ins   = imem_m[pc_m[7:2]];
  assign opc   = ins[6:0];
  assign f3    = ins[14:12];
  assign rd    = ins[11:7];
  assign rs1   = ins[19:15];
  assign rs2   = ins[24:20];
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};

  always_comb begin
    wb_en    = 1'b0;
    wb_val   = '0;
    pc_nxt   = pc_m + 32'd4;
    halt_now = 1'b0;
    case (opc)
      7'h13: if (f3 == 3'd0) begin wb_en = 1'b1; wb_val = regs[rs1] + imm_i; end
      7'h33: begin
        wb_en = 1'b1;
        case (f3)
          3'd6:    wb_val = regs[rs1] | regs[rs2];
          3'd7:    wb_val = regs[rs1] & regs[rs2];
          default: wb_val = regs[rs1] + regs[rs2];
        endcase
      end
      7'h6f: begin wb_en = 1'b1; wb_val = pc_m + 32'd4; pc_nxt = pc_m + imm_j; end
      7'h73: begin halt_now = 1'b1; pc_nxt = pc_m; end
      default: ;
    endcase
  end

  always @(posedge clk) if (imem_we) imem_m[imem_addr] <= imem_wdata;

  always @(posedge clk) begin
    if (!core_rst_n) begin
      pc_m     <= '0;
      halted_m <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (!halted_m) begin
      if (halt_now) halted_m <= 1'b1;
      else begin
        pc_m <= pc_nxt;
        if (wb_en && rd != 5'd0) regs[rd] <= wb_val;
      end
    end
  end

  // ---------------- scoreboard
  typedef struct { logic p; logic to; logic [3:0] fc; logic [2:0] ff; } res_t;
  typedef struct { logic [5:0] addr; logic [31:0] data; } wr_t;
  res_t res_q[$];
  wr_t  wr_q[$];

  initial begin : monitor
    logic done_d;
    res_t r;
    wr_t  w;
    done_d = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_we) begin
        check("imem_wr_expected", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          check("imem_addr", 32'(imem_addr), 32'(w.addr));
          check("imem_wdata", imem_wdata, w.data);
        end
      end
      if (done && !done_d) begin
        check("result_expected", 32'(res_q.size() != 0), 1);
        if (res_q.size() != 0) begin
          r = res_q.pop_front();
          check("pass", 32'(pass), 32'(r.p));
          check("timeout", 32'(timeout), 32'(r.to));
          check("fail_cnt", 32'(fail_cnt), 32'(r.fc));
          check("first_fail", 32'(first_fail), 32'(r.ff));
          check("done_busy", 32'(busy), 0);
          check("done_core_rst_n", 32'(core_rst_n), 0);
        end
      end
      done_d = done;
    end
  end

  // ---------------- stimulus helpers
  task automatic cfg_wr(input logic sel, input logic [5:0] addr, input logic [4:0] rg,
                        input logic [31:0] data, input logic with_start);
    @(negedge clk);
    check("cfg_ready", 32'(cfg_ready), 1);
    cfg_valid = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_reg = rg; cfg_data = data;
    start = with_start;
    if (sel == 1'b0) wr_q.push_back('{addr: addr, data: data});
    @(posedge clk); #1;
    cfg_valid = 1'b0; start = 1'b0;
    if (sel == 1'b0) check("imem_we_after_accept", 32'(imem_we), 1);
    @(posedge clk); #1;
    if (sel == 1'b0) check("imem_we_one_cycle", 32'(imem_we), 0);
  endtask

  task automatic expect_result(input logic p, input logic to, input logic [3:0] fc, input logic [2:0] ff);
    res_q.push_back('{p: p, to: to, fc: fc, ff: ff});
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    check("done_within_budget", 32'(done), 1);
    @(negedge clk);
  endtask

  localparam logic [31:0] PROG [9] = '{32'h00a00093, 32'h01400113, 32'h01900193, 32'h00208233,
                                       32'h003202b3, 32'h00526333, 32'h00000393, 32'h005273b3,
                                       32'h00100073};
  // x6 = 30 | 55 = 63, x7 = 30 & 55 = 22
  localparam logic [31:0] EXPV [7] = '{32'd10, 32'd20, 32'd25, 32'd30, 32'd55, 32'd63, 32'd22};

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0, t1, n;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_reg = '0;
    cfg_data = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_imem_we", 32'(imem_we), 0);
    check("rst_core_rst_n", 32'(core_rst_n), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_fail_cnt", 32'(fail_cnt), 0);
    check("rst_first_fail", 32'(first_fail), 0);
    check("rst_dbg_raddr", 32'(dbg_raddr), 0);
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    @(negedge clk); rst_n = 1'b1;

    // start together with a config write: write taken, run not started
    cfg_wr(1'b0, 6'd0, 5'd0, PROG[0], 1'b1);
    check("start_with_cfg_busy", 32'(busy), 0);
    check("start_with_cfg_core_rst_n", 32'(core_rst_n), 0);
    check("start_with_cfg_idle", 32'(cfg_ready), 1);
    for (int i = 1; i < 9; i++) cfg_wr(1'b0, 6'(i), 5'd0, PROG[i], 1'b0);
    for (int i = 0; i < 7; i++) cfg_wr(1'b1, 6'(i), 5'(i + 1), EXPV[i], 1'b0);

    // clean run
    expect_result(1'b1, 1'b0, 4'd0, 3'd0);
    pulse_start();
    check("busy_in_run", 32'(busy), 1);
    wait_done(200);

    // slot 6 now expects the wrong x7
    cfg_wr(1'b1, 6'd6, 5'd7, 32'd23, 1'b0);
    expect_result(1'b0, 1'b0, 4'd1, 3'd6);
    pulse_start();
    wait_done(200);

    // infinite loop: timeout after exactly TIMEOUT cycles, all 7 slots mismatch
    cfg_wr(1'b0, 6'd0, 5'd0, 32'h0000006f, 1'b0);
    expect_result(1'b0, 1'b1, 4'd7, 3'd0);
    pulse_start();
    check("core_released", 32'(core_rst_n), 1);
    t0 = cyc;
    n = 0;
    while (!timeout && n < 200) begin @(negedge clk); n++; end
    t1 = cyc;
    check("timeout_latency", 32'(t1 - t0), TIMEOUT);
    wait_done(200);

    // asynchronous reset in the middle of a run
    pulse_start();
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_core_rst_n", 32'(core_rst_n), 0);
    check("midrun_rst_busy", 32'(busy), 0);
    check("midrun_rst_cfg_ready", 32'(cfg_ready), 1);
    @(negedge clk); rst_n = 1'b1;

    // EBREAK at word 38 makes halt coincide with the terminal count
    for (int i = 0; i < 38; i++) cfg_wr(1'b0, 6'(i), 5'd0, 32'h00000013, 1'b0);
    cfg_wr(1'b0, 6'd38, 5'd0, 32'h00100073, 1'b0);
    expect_result(1'b1, 1'b0, 4'd0, 3'd0);
    pulse_start();
    wait_done(200);

    // x0 is compared like any register; invalid slots are skipped
    cfg_wr(1'b1, 6'd0, 5'd5, 32'd0, 1'b0);
    cfg_wr(1'b1, 6'd1, 5'd0, 32'd0, 1'b0);
    cfg_wr(1'b1, 6'd4, 5'd0, 32'd1, 1'b0);
    expect_result(1'b0, 1'b0, 4'd1, 3'd4);
    pulse_start();
    n = 0;
    while (!core_halted && n < 200) begin @(negedge clk); n++; end
    t0 = cyc;
    n = 0;
    while (dbg_raddr != 5'd5 && n < 200) begin @(negedge clk); n++; end
    t1 = cyc;
    // one RUN cycle to see the halt, DRAIN cycles, then one CHECK_REQ
    check("halt_to_dbg_raddr", 32'(t1 - t0), DRAIN + 2);
    wait_done(200);

    repeat (3) @(negedge clk);
    check("results_all_seen", 32'(res_q.size()), 0);
    check("imem_writes_all_seen", 32'(wr_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
